// File: rtl/xor_parity_rx.sv
// xor_parity_rx: serial frame receiver (start, DATA_W data LSB first, parity, stop) with parity/framing checks
module xor_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic              s_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sr;
  logic par;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (s_valid)
      nxt = state == IDLE   ? (s_bit ? IDLE : DATA) :
            state == DATA   ? (cnt == LAST ? PARITY : DATA) :
            state == PARITY ? STOP : IDLE;
  end
  assign busy = state != IDLE;
  // bits enter at the MSB and shift down, so after DATA_W bits the first one sits at bit 0
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt        <= '0;
      sr         <= '0;
      par        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (s_valid)
        case (state)
          IDLE: if (!s_bit) begin
            cnt <= '0;
            par <= ODD_PARITY;
          end
          DATA: begin
            sr  <= DATA_W'({s_bit, sr} >> 1);
            par <= par ^ s_bit;
            cnt <= cnt + 1'b1;
          end
          PARITY: par <= par ^ s_bit;
          STOP: begin
            data_out   <= sr;
            parity_err <= par;
            frame_err  <= ~s_bit;
            data_valid <= 1'b1;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_xor_parity_rx.sv
// tb_xor_parity_rx: scoreboard bench driving even- and odd-parity receivers with identical streams
module tb_xor_parity_rx;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_bit = 1'b1;
  logic [7:0] data_out, data_out_o;
  logic data_valid, parity_err, frame_err, busy;
  logic data_valid_o, parity_err_o, frame_err_o, busy_o;
  typedef struct packed {logic [7:0] d; logic pe; logic pe_o; logic fe;} exp_t;
  exp_t sb[$];
  exp_t e;
  int passed = 0, total = 0, cyc = 0, pulses = 0, busy_cyc = 0, last_pulse = 0, pulse_gap = 0, p0;
  always #5 clk = ~clk;
  xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .data_out(data_out),
    .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy));
  xor_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .data_out(data_out_o),
    .data_valid(data_valid_o), .parity_err(parity_err_o), .frame_err(frame_err_o), .busy(busy_o));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cyc++;
    if (data_valid) begin
      pulses++;
      pulse_gap = cyc - last_pulse;
      last_pulse = cyc;
      if (sb.size() == 0) check("spurious_pulse", 1, 0);
      else begin
        e = sb.pop_front();
        check("data_out", {24'b0, data_out}, {24'b0, e.d});
        check("parity_err", {31'b0, parity_err}, {31'b0, e.pe});
        check("frame_err", {31'b0, frame_err}, {31'b0, e.fe});
        check("odd_valid", {31'b0, data_valid_o}, 1);
        check("odd_data_out", {24'b0, data_out_o}, {24'b0, e.d});
        check("odd_parity_err", {31'b0, parity_err_o}, {31'b0, e.pe_o});
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b, input int gap);
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_bit = b;
    tick();
    s_valid = 1'b0;
  endtask
  task automatic frame(input logic [7:0] d, input logic p, input logic st, input int gap);
    sb.push_back('{d: d, pe: ^d ^ p, pe_o: ~(^d ^ p), fe: ~st});
    send(1'b0, gap);
    for (int i = 0; i < 8; i++) send(d[i], gap);
    send(p, gap);
    send(st, gap);
  endtask
  task automatic check_zero(string tag);
    check({tag, "_out"}, {24'b0, data_out}, 0);
    check({tag, "_flags"}, {28'b0, data_valid, parity_err, frame_err, busy}, 0);
    check({tag, "_odd_flags"}, {28'b0, data_valid_o, parity_err_o, frame_err_o, busy_o}, 0);
  endtask
  initial begin
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    busy_cyc = 0;
    frame(8'hA5, 1'b0, 1'b1, 0);
    @(negedge clk); #1;
    check("dv_latency", {31'b0, data_valid}, 1);
    @(negedge clk); #1;
    check("dv_one_cycle", {31'b0, data_valid}, 0);
    check("hold_data", {24'b0, data_out}, 32'hA5);
    check("busy_cycles", busy_cyc, 10);
    frame(8'hA5, 1'b1, 1'b1, 0);
    repeat (2) tick();
    check("hold_perr", {31'b0, parity_err}, 1);
    frame(8'h3C, 1'b0, 1'b0, 0);
    repeat (2) tick();
    frame(8'h01, 1'b1, 1'b1, 0);
    repeat (2) tick();
    p0 = pulses;
    frame(8'h5A, 1'b0, 1'b1, 3);
    repeat (3) tick();
    check("gap_pulses", pulses - p0, 1);
    p0 = pulses;
    send(1'b0, 0);
    for (int i = 0; i < 4; i++) send(i == 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_zero("midreset");
    frame(8'h81, 1'b0, 1'b1, 0);
    repeat (3) tick();
    check("abort_pulses", pulses - p0, 1);
    busy_cyc = 0;
    s_valid = 1'b1;
    s_bit = 1'b1;
    repeat (10) tick();
    s_valid = 1'b0;
    check("idle_busy", busy_cyc, 0);
    p0 = pulses;
    frame(8'hFF, 1'b0, 1'b1, 0);
    frame(8'h00, 1'b0, 1'b1, 0);
    repeat (3) tick();
    check("b2b_pulses", pulses - p0, 2);
    check("b2b_gap", pulse_gap, 11);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
Serial frame receiver that checks XOR parity: the receive-side counterpart of the team's XOR parity generation.
- Accepts a bit stream qualified by s_valid: start bit, DATA_W data bits LSB first, parity bit, stop bit.
- Deframes the data, recomputes parity with a running XOR and flags parity and framing errors.
- Sits between a serial line/bit-sampler and byte-wide consumer logic.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 1..32).
ODD_PARITY, 0, 0 = even parity (XOR of data bits and parity bit must be 0); 1 = odd parity (must be 1).

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
s_valid  input  1  qualifies s_bit; a bit is consumed only in cycles with s_valid=1.
s_bit  input  1  serial data bit.
data_out  output  DATA_W  last received data word.
data_valid  output  1  one-cycle pulse: frame complete, data_out and error flags updated.
parity_err  output  1  parity mismatch on the last frame.
frame_err  output  1  stop bit of the last frame was 0.
busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, bit counter=0, running parity=0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Reset mid-frame discards the partial frame. No data_valid is produced for it.
- States and transitions. All transitions occur only on cycles with s_valid=1; s_valid=0 holds state, counter, parity and shift register (gaps of any length allowed).
  - IDLE:
    - s_bit=0 (start bit): go to DATA; clear the counter; set parity = ODD_PARITY.
    - s_bit=1: line idle, ignored.
  - DATA:
    - Shift s_bit into bit position counter (LSB first); parity ^= s_bit; counter++.
    - After the DATA_W-th bit, go to PARITY.
  - PARITY: parity ^= s_bit; go to STOP.
  - STOP: sample the stop bit and go to IDLE.
- Frame completion (registered, 1-cycle latency):
  - The cycle after the stop bit is sampled: data_valid=1 for exactly one cycle.
  - data_out = assembled word.
  - parity_err = final running parity (nonzero means error).
  - frame_err = ~stop bit.
  - data_valid pulses even when parity_err or frame_err is set.
- Hold: data_out, parity_err and frame_err hold until the next frame completes or reset.
- busy: 1 from the cycle after start-bit acceptance through the cycle the stop bit is sampled; 0 in IDLE.
- Back-to-back frames: a start bit presented in the cycle immediately after the stop bit (the data_valid cycle) is accepted. No dead cycle is required.
- A start bit is recognised only in IDLE. A 0 seen in STOP is a framing error, not a new start.
- Counter width: $clog2(DATA_W+1). No wrap-around is possible because the counter clears at start.

Test Plan:
- Even parity, DATA_W=8, contiguous s_valid: bits 0 | 1,0,1,0,0,1,0,1 | 0 | 1 (0xA5) -> data_valid one cycle after the stop bit; data_out=0xA5, parity_err=0, frame_err=0; busy high for 10 cycles.
- Parity fault: same frame with parity bit 1 -> data_out=0xA5, parity_err=1, frame_err=0. Set ODD_PARITY=1 with parity bit 1 -> parity_err=0.
- Framing fault: 0x3C, correct parity bit 0, stop bit 0 -> data_valid=1, data_out=0x3C, frame_err=1. The next frame 0x01 (parity 1, stop 1) clears both flags.
- Gapped input: 0x5A with s_valid deasserted 3 cycles between every bit -> identical result to the contiguous case (data_out=0x5A, no errors); data_valid pulses exactly once.
- Back-to-back and idle:
  - Ten idle 1s, then 0xFF and 0x00 frames with no gap -> two data_valid pulses 11 cycles apart; outputs 0xFF then 0x00; no errors.
  - Idle 1s alone never raise busy.
- Reset mid-frame: assert rst_n=0 after 4 data bits -> all outputs 0 next cycle. A subsequent full 0x81 frame -> data_out=0x81 with no errors; no pulse for the aborted frame.
